// File: rtl/alu_flag_pkg.sv
// rtl/alu_flag_pkg.sv - shared types for the ALU flag consumer stage
// Purpose: condition-code enumeration, NZCV flag struct and table size used
//          by alu_flag_unit and cond_eval.
package alu_flag_pkg;

  localparam int NUM_COND = 16;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  // Field order matches the architectural {N,Z,C,V} view, so a flags_t can
  // be assigned straight to a 4-bit nzcv bus.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// rtl/alu_flag_unit_cond_eval.sv - combinational condition-code evaluator
// Purpose: maps an NZCV flag set and a condition selector to taken/not-taken.
// Ports:
//   flags  in   flags_t  flag set to evaluate against
//   cond   in   cond_e   condition selector
//   taken  out  1        condition result
module cond_eval
  import alu_flag_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ:      taken = flags.z;
      NE:      taken = !flags.z;
      CS:      taken = flags.c;
      CC:      taken = !flags.c;
      MI:      taken = flags.n;
      PL:      taken = !flags.n;
      VS:      taken = flags.v;
      VC:      taken = !flags.v;
      HI:      taken = flags.c & !flags.z;
      LS:      taken = !flags.c | flags.z;
      GE:      taken = (flags.n == flags.v);
      LT:      taken = (flags.n != flags.v);
      GT:      taken = !flags.z & (flags.n == flags.v);
      LE:      taken = flags.z | (flags.n != flags.v);
      AL:      taken = 1'b1;
      NV:      taken = 1'b0;  // reserved encoding, never taken
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - NZCV status register with condition-query responder
// Purpose: captures ALU flags on flag_we, answers condition queries through a
//          valid/ready handshake with a registered response, and keeps sticky
//          carry/overflow bits plus a saturating overflow-event counter.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   flag_we, in_zero/negative/carry/overflow   flag capture
//   cond_valid, cond_code, cond_ready          query request channel
//   taken_valid, taken, taken_err, taken_ready response channel
//   nzcv                             stored flags {N,Z,C,V}
//   sticky_clear, sticky_carry, sticky_overflow, ovf_count   debug state
module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             taken_valid,
  output logic             taken,
  output logic             taken_err,
  input  logic             taken_ready,
  output logic [3:0]       nzcv,
  input  logic             sticky_clear,
  output logic             sticky_carry,
  output logic             sticky_overflow,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  resp_state_e      r_state;
  resp_state_e      w_state_nxt;
  flags_t           r_flags;
  logic             r_flags_valid;
  logic             r_taken;
  logic             r_taken_err;
  logic             r_sticky_c;
  logic             r_sticky_v;
  logic [CNT_W-1:0] r_ovf_count;

  flags_t           w_in_flags;
  flags_t           w_eff_flags;
  logic             w_eff_valid;
  logic             w_accept;
  logic             w_raw_taken;
  logic             w_taken_nxt;
  logic [CNT_W-1:0] w_cnt_base;

  assign w_in_flags = {in_negative, in_zero, in_carry, in_overflow};

  // A query accepted alongside a flag write sees the incoming flags.
  assign w_eff_flags = flag_we ? w_in_flags : r_flags;
  assign w_eff_valid = flag_we | r_flags_valid;

  assign cond_ready = (r_state == ST_EMPTY) | taken_ready;
  assign w_accept   = cond_valid & cond_ready;

  cond_eval u_cond_eval (
    .flags (w_eff_flags),
    .cond  (cond_e'(cond_code)),
    .taken (w_raw_taken)
  );

  // With no flags captured yet only AL has a meaningful answer.
  assign w_taken_nxt = w_eff_valid ? w_raw_taken : (cond_code == AL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (taken_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_taken     <= 1'b0;
      r_taken_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_taken     <= w_taken_nxt;
        r_taken_err <= !w_eff_valid;
      end
    end
  end

  // Clear applies first so a simultaneous write still contributes.
  assign w_cnt_base = sticky_clear ? '0 : r_ovf_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags       <= '0;
      r_flags_valid <= 1'b0;
      r_sticky_c    <= 1'b0;
      r_sticky_v    <= 1'b0;
      r_ovf_count   <= '0;
    end else begin
      if (flag_we) begin
        r_flags       <= w_in_flags;
        r_flags_valid <= 1'b1;
      end
      r_sticky_c <= (r_sticky_c & !sticky_clear) | (flag_we & in_carry);
      r_sticky_v <= (r_sticky_v & !sticky_clear) | (flag_we & in_overflow);
      if (flag_we && in_overflow && (w_cnt_base != CNT_MAX)) begin
        r_ovf_count <= w_cnt_base + CNT_W'(1);
      end else begin
        r_ovf_count <= w_cnt_base;
      end
    end
  end

  assign taken_valid     = (r_state == ST_FULL);
  assign taken           = r_taken;
  assign taken_err       = r_taken_err;
  assign nzcv            = r_flags;
  assign sticky_carry    = r_sticky_c;
  assign sticky_overflow = r_sticky_v;
  assign ovf_count       = r_ovf_count;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - scoreboard bench for alu_flag_unit
module tb_alu_flag_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flag_we;
  logic             in_zero, in_negative, in_carry, in_overflow;
  logic             cond_valid;
  logic [3:0]       cond_code;
  logic             cond_ready;
  logic             taken_valid, taken, taken_err;
  logic             taken_ready;
  logic [3:0]       nzcv;
  logic             sticky_clear;
  logic             sticky_carry, sticky_overflow;
  logic [CNT_W-1:0] ovf_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] sb[$];   // {taken, taken_err}
  logic [1:0] exp_resp;

  always #5 clk = ~clk;

  alu_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flag_we         (flag_we),
    .in_zero         (in_zero),
    .in_negative     (in_negative),
    .in_carry        (in_carry),
    .in_overflow     (in_overflow),
    .cond_valid      (cond_valid),
    .cond_code       (cond_code),
    .cond_ready      (cond_ready),
    .taken_valid     (taken_valid),
    .taken           (taken),
    .taken_err       (taken_err),
    .taken_ready     (taken_ready),
    .nzcv            (nzcv),
    .sticky_clear    (sticky_clear),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow),
    .ovf_count       (ovf_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each negedge with valid&ready is one completed handshake.
  always @(negedge clk) begin
    if (rst_n && taken_valid && taken_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got taken=%0b err=%0b expected none", taken, taken_err);
      end else begin
        exp_resp = sb.pop_front();
        check("resp_taken", {31'd0, taken}, {31'd0, exp_resp[1]});
        check("resp_err", {31'd0, taken_err}, {31'd0, exp_resp[0]});
      end
    end
  end

  task automatic flag_write(input logic n, input logic z, input logic c, input logic v,
                            input logic clr);
    flag_we = 1'b1; in_negative = n; in_zero = z; in_carry = c; in_overflow = v;
    sticky_clear = clr;
    @(posedge clk); #1;
    flag_we = 1'b0; sticky_clear = 1'b0;
  endtask

  task automatic query(input logic [3:0] code, input logic et, input logic ee);
    cond_valid = 1'b1; cond_code = code;
    sb.push_back({et, ee});
    @(posedge clk); #1;
    cond_valid = 1'b0;
    check("latency", {31'd0, taken_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 1'b0; in_zero = 1'b0; in_negative = 1'b0;
    in_carry = 1'b0; in_overflow = 1'b0; cond_valid = 1'b0; cond_code = 4'd0;
    taken_ready = 1'b1; sticky_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_nzcv", {28'd0, nzcv}, 32'd0);
    check("rst_taken_valid", {31'd0, taken_valid}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_taken_err", {31'd0, taken_err}, 32'd0);
    check("rst_sticky", {30'd0, sticky_carry, sticky_overflow}, 32'd0);
    check("rst_ovf_count", {30'd0, ovf_count}, 32'd0);
    check("rst_cond_ready", {31'd0, cond_ready}, 32'd1);

    // No flags yet: error flagged, only AL taken.
    query(4'd0, 1'b0, 1'b1);   // EQ
    query(4'd14, 1'b1, 1'b1);  // AL

    // -5 + -1 = 1010 with carry out: N=1 Z=0 C=1 V=0
    flag_write(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("nzcv_w1", {28'd0, nzcv}, 32'hA);
    check("sticky_c_w1", {31'd0, sticky_carry}, 32'd1);
    query(4'd4, 1'b1, 1'b0);   // MI
    query(4'd2, 1'b1, 1'b0);   // CS
    query(4'd1, 1'b1, 1'b0);   // NE
    query(4'd5, 1'b0, 1'b0);   // PL

    // 1 + 7 = 1000 overflow: N=1 V=1
    flag_write(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("nzcv_w2", {28'd0, nzcv}, 32'h9);
    check("sticky_v_w2", {31'd0, sticky_overflow}, 32'd1);
    check("ovf_count_w2", {30'd0, ovf_count}, 32'd1);
    query(4'd6, 1'b1, 1'b0);   // VS
    query(4'd10, 1'b1, 1'b0);  // GE
    query(4'd11, 1'b0, 1'b0);  // LT

    // Z=1 C=1 written while EQ is queried: forwarded answer is 1.
    flag_we = 1'b1; in_negative = 1'b0; in_zero = 1'b1; in_carry = 1'b1; in_overflow = 1'b0;
    cond_valid = 1'b1; cond_code = 4'd0;
    sb.push_back(2'b10);
    check("fwd_nzcv_old", {28'd0, nzcv}, 32'h9);
    @(posedge clk); #1;
    flag_we = 1'b0; cond_valid = 1'b0;
    check("fwd_nzcv_new", {28'd0, nzcv}, 32'h6);
    query(4'd8, 1'b0, 1'b0);   // HI

    // Back-pressure: LE response (1) held while taken_ready is low.
    @(posedge clk); #1;
    taken_ready = 1'b0;
    query(4'd13, 1'b1, 1'b0);  // LE
    check("bp_cond_ready", {31'd0, cond_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, taken_valid}, 32'd1);
      check("bp_taken", {31'd0, taken}, 32'd1);
      check("bp_err", {31'd0, taken_err}, 32'd0);
      check("bp_cond_ready", {31'd0, cond_ready}, 32'd0);
    end
    taken_ready = 1'b1;
    #1 check("rel_cond_ready", {31'd0, cond_ready}, 32'd1);
    query(4'd12, 1'b0, 1'b0);  // GT back-to-back after LE
    query(4'd3, 1'b0, 1'b0);   // CC
    query(4'd15, 1'b0, 1'b0);  // NV
    query(4'd9, 1'b1, 1'b0);   // LS

    // Sticky clear alone, then saturation of the 2-bit counter.
    @(posedge clk); #1;
    sticky_clear = 1'b1;
    @(posedge clk); #1;
    sticky_clear = 1'b0;
    check("clr_sticky", {30'd0, sticky_carry, sticky_overflow}, 32'd0);
    check("clr_count", {30'd0, ovf_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      flag_write(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 2) check("count_at_3", {30'd0, ovf_count}, 32'd3);
    end
    check("count_sat", {30'd0, ovf_count}, 32'd3);
    flag_write(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_write_count", {30'd0, ovf_count}, 32'd1);
    check("clr_write_sticky_v", {31'd0, sticky_overflow}, 32'd1);
    check("clr_write_sticky_c", {31'd0, sticky_carry}, 32'd0);

    // Reset with a response pending: it is dropped.
    taken_ready = 1'b0;
    query(4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    taken_ready = 1'b1;
    check("midrst_valid", {31'd0, taken_valid}, 32'd0);
    check("midrst_nzcv", {28'd0, nzcv}, 32'd0);
    check("midrst_count", {30'd0, ovf_count}, 32'd0);
    query(4'd0, 1'b0, 1'b1);   // flags invalid again

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
